// File: rtl/time_display_scan_if.sv
// Digit bus between the countdown timer and the display scanner: three BCD-ish
// digits in, active-low anode/segment/dp pins out.
interface time_display_scan_if;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] C;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (output A, B, C, input an, seg, dp);
    modport slave  (input A, B, C, output an, seg, dp);
endinterface

// File: rtl/time_display_scan.sv
// Time-multiplexed 4-digit common-anode scanner with per-frame shadowing and a dark
// cycle before every digit switch. Optional 0:00 blink enabled by defining ZERO_BLINK_EN.
module time_display_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk_in,
    input  logic                  reset,
    time_display_scan_if.slave    bus
);

    typedef enum logic [1:0] {
        SLOT_C     = 2'd0,
        SLOT_B     = 2'd1,
        SLOT_A     = 2'd2,
        SLOT_BLANK = 2'd3
    } slot_t;

    localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    slot_t         slot;
    slot_t         slot_next;
    logic          tick;
    logic          frame_start;
    logic [3:0]    sA;
    logic [3:0]    sB;
    logic [3:0]    sC;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;
    logic          hidden;

    function automatic logic [6:0] decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b0111111;
        endcase
        return pattern;
    endfunction

    assign tick        = (cnt == CNT_LAST);
    assign frame_start = tick && (slot == SLOT_BLANK);

`ifdef ZERO_BLINK_EN
    logic [7:0] blink_cnt;
    logic       blink_hidden;
    logic       latch_zero;

    assign latch_zero = (bus.A == 4'd0) && (bus.B == 4'd0) && (bus.C == 4'd0);

    // The counter reloads to 1 on a toggle because the frame being started is already
    // the first frame of the new phase.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            blink_cnt    <= 8'd0;
            blink_hidden <= 1'b0;
        end else if (frame_start) begin
            if (!latch_zero) begin
                blink_cnt    <= 8'd0;
                blink_hidden <= 1'b0;
            end else if (blink_cnt == 8'(BLINK_FRAMES)) begin
                blink_cnt    <= 8'd1;
                blink_hidden <= ~blink_hidden;
            end else begin
                blink_cnt    <= blink_cnt + 8'd1;
            end
        end
    end

    assign hidden = blink_hidden;
`else
    assign hidden = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt  <= '0;
            slot <= SLOT_BLANK;
        end else begin
            cnt  <= tick ? '0 : cnt + 1'b1;
            slot <= slot_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sA <= 4'd0;
            sB <= 4'd0;
            sC <= 4'd0;
        end else if (frame_start) begin
            sA <= bus.A;
            sB <= bus.B;
            sC <= bus.C;
        end
    end

    // Tick edges always go dark; every other edge lights the current slot from shadows.
    always_comb begin
        slot_next = slot;
        an_next   = 4'b1111;
        seg_next  = 7'b1111111;
        dp_next   = 1'b1;
        if (tick) begin
            case (slot)
                SLOT_C:  slot_next = SLOT_B;
                SLOT_B:  slot_next = SLOT_A;
                SLOT_A:  slot_next = SLOT_BLANK;
                default: slot_next = SLOT_C;
            endcase
        end else if (!hidden) begin
            case (slot)
                SLOT_C: begin
                    an_next  = 4'b1110;
                    seg_next = decode(sC);
                end
                SLOT_B: begin
                    an_next  = 4'b1101;
                    seg_next = decode(sB);
                end
                SLOT_A: begin
                    an_next  = 4'b1011;
                    seg_next = decode(sA);
                    dp_next  = 1'b0;
                end
                default: begin
                    an_next  = 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            bus.an  <= 4'b1111;
            bus.seg <= 7'b1111111;
            bus.dp  <= 1'b1;
        end else begin
            bus.an  <= an_next;
            bus.seg <= seg_next;
            bus.dp  <= dp_next;
        end
    end

endmodule

// File: doc/time_display_scan.md
# time_display_scan

Display-side consumer of the countdown timer's digit outputs: takes minutes digit A, tens-of-seconds digit B and units-of-seconds digit C and drives the board's 4-digit common-anode seven-segment display by time-multiplexed scanning. Inputs are sampled once per frame into shadow registers to prevent tearing, and every digit switch is preceded by one dark cycle to suppress ghosting. Optional blink on 0:00 signals time-out. Sits between the timer and the top-level display pins in time mode.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal range 2..2^20.
- BLINK_FRAMES, 64: frames per blink half-period (used only with ZERO_BLINK_EN); legal range 1..255.
- clk_in  input  1  system clock; one clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  4  minutes digit, binary 0..15.
- B  input  4  tens-of-seconds digit, binary 0..15.
- C  input  4  units-of-seconds digit, binary 0..15.
- an  output  4  digit enables, active-low; an[0] = rightmost.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; used as minutes/seconds separator.

## Operation
- Divider: cnt runs 0..REFRESH_DIV-1 and wraps; tick = (cnt == REFRESH_DIV-1).
- Scan index idx (2 bits) advances on each tick edge, wraps 3 -> 0. Slot map: 0 -> C, 1 -> B, 2 -> A with dp = 0, 3 -> always blank (an[3] never asserted; keeps duty cycle uniform).
- Frame start: tick edge with idx == 3 copies A, B, C into shadow registers sA, sB, sC. Display uses shadows only; input changes are invisible until the next frame start.
- Digit decode (active-low, {g..a}): 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000; 10..15 -> dash 0111111; blank 1111111.
- Dark cycle: on every tick edge an <= 1111, seg <= 1111111, dp <= 1. On every non-tick edge an/seg/dp are driven from current idx and shadows (an = one-hot low for idx 0..2, 1111 for idx 3).
- All outputs registered; no combinational path from A/B/C to pins.
- Reset values: cnt = 0, idx = 3, sA = sB = sC = 0, an = 1111, seg = 1111111, dp = 1, blink frame counter = 0, blink phase = visible. Reset wins over tick in the same cycle; asserting reset mid-frame returns all state to these values on that edge.

## Timing
- Edge k after reset release (k = 1,2,...): tick occurs when k = REFRESH_DIV; that edge latches shadows, sets idx = 0, outputs dark.
- Each slot: 1 dark cycle + REFRESH_DIV-1 lit cycles. Frame = 4*REFRESH_DIV cycles.
- Input-to-pin latency: up to 4*REFRESH_DIV+1 cycles (next frame start + 1).
- Blink phase changes only at frame start, so a frame is never partially blanked.

## Configuration
- ZERO_BLINK_EN defined: at each frame start, if the newly latched sA = sB = sC = 0, a frame counter increments; after BLINK_FRAMES frames it clears and blink phase toggles. While phase = hidden, an is forced to 1111 for the whole frame (seg/dp don't-care but driven 1111111/1). Any nonzero latched value clears the counter and sets phase = visible in that same frame.
- ZERO_BLINK_EN undefined: no frame counter or phase logic; 0:00 displays steadily like any other value.

## Test plan
- Reset: drive garbage on A/B/C, hold reset 3 cycles -> an = 1111, seg = 1111111, dp = 1; pulse reset mid-slot 1 -> same values on that edge, next tick again after REFRESH_DIV edges.
- REFRESH_DIV = 4, A = 2, B = 5, C = 9: edge 4 dark; edges 5-7 an = 1110, seg = 0010000, dp = 1; edge 8 dark; edges 9-11 an = 1101, seg = 0010010; edges 13-15 an = 1011, seg = 0100100, dp = 0; edges 17-19 an = 1111.
- Tearing: same setup, change C to 8 during slot 1 -> slot 0 of current frame already passed; slot 0 of the next frame shows 0000000; no intermediate value ever appears.
- Out-of-range digit: B = 12 -> slot 1 shows seg = 0111111.
- ZERO_BLINK_EN, REFRESH_DIV = 4, BLINK_FRAMES = 2, A = B = C = 0: frames 1-2 show 0 on slots 0-2 (seg = 1000000), frames 3-4 an = 1111 throughout, frames 5-6 visible; set C = 1 during hidden frame -> next frame visible, counter restarts.
- ZERO_BLINK_EN undefined, same stimulus -> every frame visible with seg = 1000000 on slots 0-2.
